// File: rtl/apb_master.sv
// Single-word APB3/APB4 requester: local valid/ready command port in, one response pulse out.
// Optional wait-state watchdog is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master #(
   parameter int addrWidth = 8,
   parameter int dataWidth = 32,
   parameter int TIMEOUT   = 16
) (
   input  logic                   pclk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_write,
   input  logic [addrWidth-1:0]   cmd_addr,
   input  logic [dataWidth-1:0]   cmd_wdata,
   input  logic [dataWidth/8-1:0] cmd_strb,
   output logic                   rsp_valid,
   output logic [dataWidth-1:0]   rsp_rdata,
   output logic                   rsp_err,
   output logic                   psel,
   output logic                   penable,
   output logic                   pwrite,
   output logic [addrWidth-1:0]   paddr,
   output logic [dataWidth-1:0]   pwdata,
   output logic [dataWidth/8-1:0] pstrb,
   input  logic [dataWidth-1:0]   prdata,
   input  logic                   pready
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;

   logic [1:0] state;
   logic       timed_out;
   logic       done;

   assign cmd_ready = (state == IDLE);
   assign done      = pready || timed_out;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wait_cnt;

   // wait_cnt holds the stalls seen so far, so this edge is the TIMEOUT-th stall.
   assign timed_out = (state == ACCESS) && !pready && (wait_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         wait_cnt <= '0;
         rsp_err  <= 1'b0;
      end else begin
         if (state == SETUP)
            wait_cnt <= '0;
         else if (state == ACCESS && !pready && !timed_out)
            wait_cnt <= wait_cnt + 1'b1;
         if (state == ACCESS && done)
            rsp_err <= timed_out && !pready;
      end
   end
`else
   // TIMEOUT only matters when the watchdog is built.
   localparam int unused_timeout = TIMEOUT;
   assign timed_out = 1'b0;
   assign rsp_err   = 1'b0;
`endif

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         state     <= IDLE;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         pstrb     <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  paddr   <= cmd_addr;
                  pwrite  <= cmd_write;
                  pwdata  <= cmd_wdata;
                  pstrb   <= cmd_write ? cmd_strb : '0;
                  psel    <= 1'b1;
                  penable <= 1'b0;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               penable <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS: begin
               if (done) begin
                  rsp_rdata <= (pwrite || !pready) ? '0 : prdata;
                  rsp_valid <= 1'b1;
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               psel    <= 1'b0;
               penable <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: command-level memory model vs. a wait-state APB slave.
// Timeout expectations follow APB_MASTER_TIMEOUT_EN.
module tb_apb_master;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 16;

   logic          pclk, rst_n;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [SW-1:0] cmd_strb;
   logic          rsp_valid, rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [SW-1:0] pstrb;
   logic [DW-1:0] prdata;
   logic          pready;

   apb_master #(.addrWidth(AW), .dataWidth(DW), .TIMEOUT(TO)) dut (
      .pclk(pclk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int cyc = 0;
   always @(posedge pclk) cyc++;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] strb;
      logic [DW-1:0] rdata;
      logic          err;
      int            k;
      int            lat;
      bit            never;
   } exp_t;

   exp_t          sb[$];
   int            waitq[$];
   logic [DW-1:0] ref_mem [256];
   logic [DW-1:0] slv_mem [256];
   int            checks = 0;
   int            errors = 0;
   int            rsp_count = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // APB slave: wait-state count per transfer from waitq (-1 = never ready), random pready elsewhere.
   int stall = 0;
   always begin
      @(posedge pclk);
      #2;
      if (psel && !penable) begin
         stall  = (waitq.size() > 0) ? waitq.pop_front() : 0;
         pready = 1'($urandom_range(0, 1));
      end else if (psel && penable) begin
         if (stall < 0) pready = 1'b0;
         else if (stall == 0) pready = 1'b1;
         else begin
            pready = 1'b0;
            stall--;
         end
      end else begin
         pready = 1'($urandom_range(0, 1));
      end
      prdata = (pready && psel && penable && !pwrite) ? slv_mem[paddr] : $urandom;
      if (pready && psel && penable && pwrite)
         for (int b = 0; b < SW; b++)
            if (pstrb[b]) slv_mem[paddr][8*b +: 8] = pwdata[8*b +: 8];
   end

   // Monitor: bus contents against the in-flight command, responses against the scoreboard.
   exp_t mon_e;
   bit   prev_psel = 1'b0;
   always @(negedge pclk) begin
      if (rst_n) begin
         if (psel && sb.size() > 0) begin
            mon_e = sb[0];
            check("bus", {pwrite, paddr, pwdata, pstrb},
                  {mon_e.wr, mon_e.addr, mon_e.wdata, mon_e.wr ? mon_e.strb : 4'h0});
         end
         if (penable) check("penable_after_setup", {63'd0, prev_psel}, 64'd1);
         if (rsp_valid) begin
            rsp_count++;
            if (sb.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
            else begin
               mon_e = sb.pop_front();
               if (mon_e.never) check("rsp_unexpected", 64'd1, 64'd0);
               else begin
                  check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, mon_e.rdata});
                  check("rsp_err", {63'd0, rsp_err}, {63'd0, mon_e.err});
                  check("rsp_latency", 64'(cyc - mon_e.k), 64'(mon_e.lat));
               end
            end
         end
      end
      prev_psel = psel;
   end

   // Enters with inputs at posedge+1; returns at posedge+1 after the accepting edge, cmd_valid still high.
   task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input int w, output int k);
      exp_t e;
      int   n = 0;
      cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_valid = 1'b1;
      @(negedge pclk);
      while (!cmd_ready && n < 200) begin
         @(negedge pclk);
         n++;
      end
      if (!cmd_ready) begin
         check("accept_timeout", 64'd0, 64'd1);
         k = -1;
         return;
      end
      k = cyc + 1;
      e.wr = wr; e.addr = a; e.wdata = d; e.strb = s; e.k = k;
      e.err = 1'b0; e.lat = 2 + w; e.never = 1'b0;
      if (wr) begin
         e.rdata = '0;
         if (w >= 0)
            for (int b = 0; b < SW; b++)
               if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      end else begin
         e.rdata = ref_mem[a];
      end
      if (w < 0) begin
`ifdef APB_MASTER_TIMEOUT_EN
         e.err = 1'b1; e.rdata = '0; e.lat = 1 + TO;
`else
         e.never = 1'b1;
`endif
      end
      sb.push_back(e);
      waitq.push_back(w);
      @(posedge pclk);
      #1;
   endtask

   task automatic idle(input int n);
      cmd_valid = 1'b0;
      repeat (n) @(posedge pclk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() > 0 && n < 300) begin
         @(negedge pclk);
         n++;
      end
      if (sb.size() > 0) check("drain_timeout", 64'(sb.size()), 64'd0);
      @(posedge pclk);
      #1;
   endtask

   // Reset pulse from posedge+1; checks the cycle after the reset edge.
   task automatic reset_pulse(input string name);
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      sb.delete();
      waitq.delete();
      @(posedge pclk);
      @(negedge pclk);
      check(name, {60'd0, psel, penable, rsp_valid, cmd_ready}, 64'd1);
      @(posedge pclk);
      #1;
      rst_n = 1'b1;
      @(negedge pclk);
      check({name, "_ready"}, {63'd0, cmd_ready}, 64'd1);
      @(posedge pclk);
      #1;
   endtask

   int k1, k2, kx, base;
   initial begin
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = '0;
         slv_mem[i] = '0;
      end
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
      cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
      pready = 1'b0; prdata = '0;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      check("reset_ctrl", {50'd0, psel, penable, pwrite, rsp_valid, rsp_err, cmd_ready, paddr, pstrb},
            {50'd0, 6'b000001, 8'h00, 4'h0});
      check("reset_data", {pwdata, rsp_rdata}, 64'd0);
      @(posedge pclk);
      #1;
      rst_n = 1'b1;

      issue(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 0, kx);
      idle(1);
      drain();
      issue(1'b0, 8'h10, $urandom, 4'($urandom_range(0, 15)), 0, kx);
      idle(1);
      drain();
      issue(1'b1, 8'h20, 32'h12345678, 4'h5, 3, kx);
      idle(1);
      issue(1'b0, 8'h20, $urandom, 4'hF, 3, kx);
      idle(1);
      drain();

      issue(1'b1, 8'h00, $urandom, 4'hF, 0, k1);
      issue(1'b1, 8'h04, $urandom, 4'hF, 0, k2);
      idle(1);
      drain();
      check("b2b_gap", 64'(k2 - k1), 64'd3);

      issue(1'b0, 8'h10, $urandom, 4'h0, 10, kx);
      repeat (3) @(posedge pclk);
      #1;
      reset_pulse("reset_mid");

      issue(1'b0, 8'h30, $urandom, 4'h0, -1, kx);
      idle(0);
`ifdef APB_MASTER_TIMEOUT_EN
      drain();
`else
      base = rsp_count;
      repeat (100) @(posedge pclk);
      @(negedge pclk);
      check("hang_psel", {63'd0, psel}, 64'd1);
      check("hang_no_rsp", 64'(rsp_count - base), 64'd0);
      @(posedge pclk);
      #1;
      reset_pulse("reset_hang");
`endif

      for (int i = 0; i < 150; i++) begin
         issue(1'($urandom_range(0, 1)), 8'({$urandom_range(0, 7), 2'b00}), $urandom,
               4'($urandom_range(0, 15)), int'($urandom_range(0, 4)), kx);
         if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 3)));
      end
      idle(1);
      drain();
      check("sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
